spell_mem_loader: RTL and testbench
===================================

// Module: spell_mem_loader
// PURPOSE
//  Byte-stream program loader that sits directly upstream of the DFF code/data memory and drives its select/write port.
//  Receives framed bytes on a valid/ready stream: CMD, ADDR, LEN, then LEN payload bytes.
//  Writes payload to sequential addresses, or in verify mode reads them back and compares.
//  Holds the core off the memory bus (busy) while a frame is in progress.
// PARAMETERS
//  TIMEOUT    16  max cycles in ACCESS waiting for mem_data_ready before aborting (>=2)
// PORTS
//  clock           in   1  single clock; all logic on posedge
//  reset           in   1  synchronous, active-low (0 = reset)
//  in_valid        in   1  stream byte valid
//  in_data         in   8  stream byte
//  in_ready        out  1  loader can accept a byte this cycle
//  mem_select      out  1  memory select
//  mem_addr        out  8  memory address
//  mem_wdata       out  8  memory write data
//  mem_type_data   out  1  1 = data memory, 0 = code memory
//  mem_write       out  1  1 = write, 0 = read
//  mem_rdata       in   8  memory read data
//  mem_data_ready  in   1  memory access complete
//  busy            out  1  frame in progress (state != IDLE)
//  done            out  1  1-cycle pulse when a frame completes normally
//  error           out  1  sticky: verify mismatch or timeout; cleared when next CMD accepted
//  error_addr      out  8  address of first mismatch/timeout in current frame
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE; all outputs 0 except in_ready=1; partial frame discarded, mem_select drops same edge.
//  Byte accepted when in_valid && in_ready. in_ready=1 only in IDLE, GET_ADDR, GET_LEN, GET_DATA.
//  CMD byte: [7]=mem_type_data, [6]=verify, [5:0] ignored. Accepting CMD clears error, error_addr.
//  States: IDLE -(CMD)-> GET_ADDR -(byte: addr reg)-> GET_LEN -(byte: count reg)->
//   count==0 ? DONE : GET_DATA -(byte: latch)-> ACCESS -> RELEASE -> (count==0 ? DONE : GET_DATA); DONE -> IDLE.
//  ACCESS: registered mem_select=1, mem_addr=addr, mem_wdata=byte, mem_write=!verify; stable throughout.
//   On mem_data_ready==1: verify && mem_rdata!=byte -> error=1, error_addr=addr (first only); go RELEASE.
//   Timeout counter cleared on ACCESS entry; reaching TIMEOUT cycles without ready -> error=1,
//   error_addr=addr, mem_select=0, go IDLE (no done, rest of frame NOT consumed by loader).
//  RELEASE: mem_select=0; wait until mem_data_ready==0, then addr<=addr+1 (8-bit wrap 255->0), count<=count-1.
//  Mismatch does not abort: remaining bytes still verified.
//  DONE: done=1 for exactly one cycle, busy=1 in that cycle; next cycle IDLE, busy=0.
//  Out-of-range addresses issued unchanged; memory ignores them (verify of those reads expects 0).
//  in_valid ignored while in_ready==0; in_data need not be held.
//  Minimum cost per payload byte: 1 accept + ACCESS (>=2) + RELEASE (>=1) cycles.
// TESTING
//  Write 3 bytes: CMD=8'h00, ADDR=8'h04, LEN=3, 8'hA1,8'hB2,8'hC3 -> code_mem[4..6]=A1,B2,C3; one done pulse; error=0.
//  Verify: CMD=8'h40, ADDR=8'h04, LEN=3, A1,B2,FF -> error=1, error_addr=8'h06, done pulses.
//  Data mem + wrap: CMD=8'h80, ADDR=8'hFF, LEN=2, 11,22 -> writes at FF (ignored) then 00 (data_mem[0]=22).
//  LEN=0: CMD, ADDR=5, LEN=0 -> no mem_select assertion, done 1 cycle after LEN accepted.
//  Timeout: tie mem_data_ready=0, send 1-byte write -> after TIMEOUT cycles error=1, busy=0, no done.
//  Reset mid-ACCESS: reset=0 one cycle -> mem_select=0, busy=0, in_ready=1; new frame then completes normally.

Source files
------------

// File: rtl/spell_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spell_mem_loader
//  Description : Byte-stream program loader for the code/data memory.
//                Frames arrive as CMD, ADDR, LEN, then LEN payload bytes.
//                Payload is written to sequential addresses, or read back
//                and compared in verify mode. The memory port is held
//                (busy) for the whole frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module spell_mem_loader #(
    parameter int TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_type_data,
    output logic       mem_write,
    input  logic [7:0] mem_rdata,
    input  logic       mem_data_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] error_addr
);

    // Counter wide enough to hold TIMEOUT-1; the last count triggers abort.
    localparam int              c_cnt_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_LEN  = 3'd2,
        S_GET_DATA = 3'd3,
        S_ACCESS   = 3'd4,
        S_RELEASE  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           count_q, count_d;
    logic [7:0]           data_byte_q, data_byte_d;
    logic                 verify_q, verify_d;
    logic [c_cnt_w-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 mem_select_q, mem_select_d;
    logic [7:0]           mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 mem_type_data_q, mem_type_data_d;
    logic                 mem_write_q, mem_write_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [7:0]           error_addr_q, error_addr_d;

    logic                 w_accept;

    assign w_accept = in_valid && in_ready_q;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        count_d         = count_q;
        data_byte_d     = data_byte_q;
        verify_d        = verify_q;
        tmo_cnt_d       = tmo_cnt_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_type_data_d = mem_type_data_q;
        mem_write_d     = mem_write_q;
        error_d         = error_q;
        error_addr_d    = error_addr_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    mem_type_data_d = in_data[7];
                    verify_d        = in_data[6];
                    error_d         = 1'b0;
                    error_addr_d    = 8'd0;
                    state_d         = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (w_accept) begin
                    addr_d  = in_data;
                    state_d = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                if (w_accept) begin
                    count_d = in_data;
                    state_d = (in_data == 8'd0) ? S_DONE : S_GET_DATA;
                end
            end
            S_GET_DATA: begin
                if (w_accept) begin
                    data_byte_d = in_data;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    mem_write_d = !verify_q;
                    tmo_cnt_d   = '0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_data_ready) begin
                    // A mismatch is recorded but the frame carries on.
                    if (verify_q && (mem_rdata != data_byte_q) && !error_q) begin
                        error_d      = 1'b1;
                        error_addr_d = addr_q;
                    end
                    state_d = S_RELEASE;
                end else if (tmo_cnt_q == c_tmo_last) begin
                    // Abort: remaining frame bytes are left for the sender.
                    if (!error_q) begin
                        error_addr_d = addr_q;
                    end
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_cnt_w'(1);
                end
            end
            S_RELEASE: begin
                // Handshake completes only once the memory drops ready.
                if (!mem_data_ready) begin
                    addr_d  = addr_q + 8'd1;
                    count_d = count_q - 8'd1;
                    state_d = (count_q == 8'd1) ? S_DONE : S_GET_DATA;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d   = (state_d == S_IDLE) || (state_d == S_GET_ADDR) ||
                       (state_d == S_GET_LEN) || (state_d == S_GET_DATA);
        mem_select_d = (state_d == S_ACCESS);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // State and registered outputs; active-low synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            addr_q          <= 8'd0;
            count_q         <= 8'd0;
            data_byte_q     <= 8'd0;
            verify_q        <= 1'b0;
            tmo_cnt_q       <= '0;
            in_ready_q      <= 1'b1;
            mem_select_q    <= 1'b0;
            mem_addr_q      <= 8'd0;
            mem_wdata_q     <= 8'd0;
            mem_type_data_q <= 1'b0;
            mem_write_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            error_addr_q    <= 8'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            count_q         <= count_d;
            data_byte_q     <= data_byte_d;
            verify_q        <= verify_d;
            tmo_cnt_q       <= tmo_cnt_d;
            in_ready_q      <= in_ready_d;
            mem_select_q    <= mem_select_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_type_data_q <= mem_type_data_d;
            mem_write_q     <= mem_write_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            error_addr_q    <= error_addr_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_select    = mem_select_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_type_data = mem_type_data_q;
    assign mem_write     = mem_write_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign error_addr    = error_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_spell_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spell_mem_loader
//  Description : Self-checking bench for spell_mem_loader with a small
//                16-entry code/data memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spell_mem_loader;

    localparam int TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       mem_select;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_type_data;
    logic       mem_write;
    logic [7:0] mem_rdata;
    logic       mem_data_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] error_addr;

    logic       mem_stall = 1'b0;
    logic [7:0] code_mem [16];
    logic [7:0] data_mem [16];

    int n_pass  = 0;
    int n_total = 0;

    int sel_rises  = 0;
    int sel_cycles = 0;
    int done_cycles = 0;
    logic sel_prev = 1'b0;

    spell_mem_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_select     (mem_select),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_type_data  (mem_type_data),
        .mem_write      (mem_write),
        .mem_rdata      (mem_rdata),
        .mem_data_ready (mem_data_ready),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .error_addr     (error_addr)
    );

    always #5 clock = ~clock;

    // Memory model: one access per select, ready one cycle later, ready drops after select.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                code_mem[i] <= 8'd0;
                data_mem[i] <= 8'd0;
            end
            mem_data_ready <= 1'b0;
            mem_rdata      <= 8'd0;
        end else if (mem_select && !mem_stall) begin
            if (!mem_data_ready) begin
                mem_data_ready <= 1'b1;
                if (mem_write) begin
                    mem_rdata <= 8'd0;
                    if (mem_addr < 8'd16) begin
                        if (mem_type_data) data_mem[mem_addr[3:0]] <= mem_wdata;
                        else               code_mem[mem_addr[3:0]] <= mem_wdata;
                    end
                end else begin
                    if (mem_addr < 8'd16)
                        mem_rdata <= mem_type_data ? data_mem[mem_addr[3:0]] : code_mem[mem_addr[3:0]];
                    else
                        mem_rdata <= 8'd0;
                end
            end
        end else begin
            mem_data_ready <= 1'b0;
        end
    end

    // Free-running activity counters sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_select) sel_cycles <= sel_cycles + 1;
        if (mem_select && !sel_prev) sel_rises <= sel_rises + 1;
        if (done) done_cycles <= done_cycles + 1;
        sel_prev <= mem_select;
    end

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] len;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       exp_err;
        logic [7:0] exp_eaddr;
        logic       chk_dmem;
        logic [3:0] chk_addr;
        logic [7:0] chk_val;
    } frame_t;

    frame_t vec [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_wait: in_ready stuck at %0b for byte %0h", in_ready, b);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("idle_wait_busy", {31'd0, busy}, 32'd0);
    endtask

    function automatic frame_t mk(input logic [7:0] cmd, input logic [7:0] addr,
                                  input logic [7:0] len, input logic [7:0] b0,
                                  input logic [7:0] b1, input logic [7:0] b2,
                                  input logic exp_err, input logic [7:0] exp_eaddr,
                                  input logic chk_dmem, input logic [3:0] chk_addr,
                                  input logic [7:0] chk_val);
        frame_t f;
        f.cmd = cmd; f.addr = addr; f.len = len;
        f.b0 = b0; f.b1 = b1; f.b2 = b2;
        f.exp_err = exp_err; f.exp_eaddr = exp_eaddr;
        f.chk_dmem = chk_dmem; f.chk_addr = chk_addr; f.chk_val = chk_val;
        return f;
    endfunction

    task automatic run_frame(input frame_t f, input int idx);
        int d0, s0;
        logic [7:0] mv;
        d0 = done_cycles;
        s0 = sel_rises;
        send_byte(f.cmd);
        send_byte(f.addr);
        send_byte(f.len);
        if (f.len > 0) send_byte(f.b0);
        if (f.len > 1) send_byte(f.b1);
        if (f.len > 2) send_byte(f.b2);
        wait_idle();
        chk($sformatf("v%0d_done", idx), 32'(done_cycles - d0), 32'd1);
        chk($sformatf("v%0d_selects", idx), 32'(sel_rises - s0), 32'(f.len));
        chk($sformatf("v%0d_error", idx), {31'd0, error}, {31'd0, f.exp_err});
        chk($sformatf("v%0d_error_addr", idx), {24'd0, error_addr}, {24'd0, f.exp_eaddr});
        mv = f.chk_dmem ? data_mem[f.chk_addr] : code_mem[f.chk_addr];
        chk($sformatf("v%0d_mem", idx), {24'd0, mv}, {24'd0, f.chk_val});
    endtask

    initial begin
        int d0, c0, n;

        vec[0] = mk(8'h00, 8'h04, 8'd3, 8'hA1, 8'hB2, 8'hC3, 1'b0, 8'h00, 1'b0, 4'd5, 8'hB2);
        vec[1] = mk(8'h40, 8'h04, 8'd3, 8'hA1, 8'hB2, 8'hFF, 1'b1, 8'h06, 1'b0, 4'd6, 8'hC3);
        vec[2] = mk(8'h80, 8'hFF, 8'd2, 8'h11, 8'h22, 8'h00, 1'b0, 8'h00, 1'b1, 4'd0, 8'h22);
        vec[3] = mk(8'hC0, 8'hFF, 8'd2, 8'h00, 8'h22, 8'h00, 1'b0, 8'h00, 1'b1, 4'd0, 8'h22);
        vec[4] = mk(8'h00, 8'h05, 8'd0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 4'd5, 8'hB2);
        vec[5] = mk(8'h7F, 8'h04, 8'd3, 8'hA0, 8'hB2, 8'hC3, 1'b1, 8'h04, 1'b0, 4'd4, 8'hA1);
        vec[6] = mk(8'h80, 8'h03, 8'd1, 8'h5A, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 4'd3, 8'h5A);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_select", {31'd0, mem_select}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_error_addr", {24'd0, error_addr}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 7; i++) run_frame(vec[i], i);

        // Timeout: memory never answers
        mem_stall = 1'b1;
        d0 = done_cycles;
        c0 = sel_cycles;
        send_byte(8'h00);
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h77);
        wait_idle();
        chk("tmo_done", 32'(done_cycles - d0), 32'd0);
        chk("tmo_sel_cycles", 32'(sel_cycles - c0), 32'(TIMEOUT));
        chk("tmo_error", {31'd0, error}, 32'd1);
        chk("tmo_error_addr", {24'd0, error_addr}, 32'h08);
        chk("tmo_in_ready", {31'd0, in_ready}, 32'd1);
        chk("tmo_mem", {24'd0, code_mem[8]}, 32'd0);
        mem_stall = 1'b0;

        // Next frame after timeout clears error
        run_frame(mk(8'h00, 8'h09, 8'd1, 8'h33, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 4'd9, 8'h33), 7);

        // Reset in the middle of an access
        mem_stall = 1'b1;
        send_byte(8'h00);
        send_byte(8'h0A);
        send_byte(8'h02);
        send_byte(8'h44);
        n = 0;
        @(negedge clock);
        while (!mem_select && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("mid_sel_seen", {31'd0, mem_select}, 32'd1);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        chk("mid_rst_select", {31'd0, mem_select}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        mem_stall = 1'b0;
        run_frame(mk(8'h00, 8'h0A, 8'd1, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 4'd10, 8'h55), 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
